// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus controller.
// State encoding, strobe constants and the word-address width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] STB_NONE = 4'b0000;
  localparam logic [3:0] STB_WORD = 4'b1111;

  localparam int AW = 30;

endpackage

// File: rtl/dmem_timeout.sv
// Bus wait-state watchdog: counts cycles while enabled and flags the
// cycle in which the count would reach TIMEOUT.
module dmem_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  // Fires in the TIMEOUT-th enabled cycle after a clear.
  assign expire = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// M-stage data-memory access controller: runs each aligner access as a
// valid/ready bus transaction and stalls the pipe until it completes.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ_RD,
  input  logic          REQ_WR,
  input  logic [AW-1:0] MADDR,
  input  logic [31:0]   MDATAO,
  input  logic [3:0]    MWSTB,
  output logic [31:0]   MDATAI,
  output logic          STALL,
  output logic          ERR,
  output logic          BUS_VALID,
  input  logic          BUS_READY,
  output logic          BUS_WRITE,
  output logic [AW-1:0] BUS_ADDR,
  output logic [31:0]   BUS_WDATA,
  output logic [3:0]    BUS_WSTB,
  input  logic          BUS_RVALID,
  input  logic [31:0]   BUS_RDATA,
  input  logic          BUS_ERR
);

  state_e state;
  logic   req;
  logic   tmo_clr;
  logic   tmo_en;
  logic   tmo_exp;

  assign req   = REQ_RD | REQ_WR;
  assign STALL = req & (state != DONE);

  // Clear on every entry into a wait state.
  assign tmo_clr = ((state == IDLE) & req)
                 | ((state == ADDR) & BUS_READY & ~BUS_WRITE);
  assign tmo_en  = (state == ADDR) | (state == RWAIT);

  dmem_timeout #(
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_tmo (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .expire(tmo_exp)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      MDATAI    <= '0;
      ERR       <= 1'b0;
      BUS_VALID <= 1'b0;
      BUS_WRITE <= 1'b0;
      BUS_ADDR  <= '0;
      BUS_WDATA <= '0;
      BUS_WSTB  <= STB_NONE;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            BUS_ADDR  <= MADDR;
            BUS_WDATA <= MDATAO;
            BUS_WRITE <= REQ_WR;
            BUS_WSTB  <= REQ_WR ? MWSTB : STB_NONE;
            BUS_VALID <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // A handshake in the expiry cycle still wins.
          if (BUS_READY) begin
            BUS_VALID <= 1'b0;
            if (BUS_WRITE) begin
              ERR   <= BUS_ERR;
              state <= DONE;
            end else begin
              state <= RWAIT;
            end
          end else if (tmo_exp) begin
            BUS_VALID <= 1'b0;
            ERR       <= 1'b1;
            if (!BUS_WRITE) begin
              MDATAI <= '0;
            end
            state <= DONE;
          end
        end
        RWAIT: begin
          if (BUS_RVALID) begin
            MDATAI <= BUS_ERR ? 32'h0 : BUS_RDATA;
            ERR    <= BUS_ERR;
            state  <= DONE;
          end else if (tmo_exp) begin
            MDATAI <= '0;
            ERR    <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: random accesses against a
// transaction-level model, with a randomized bus responder.
module tb_dmem_bus_ctrl;

  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_RD = 1'b0;
  logic        REQ_WR = 1'b0;
  logic [29:0] MADDR = '0;
  logic [31:0] MDATAO = '0;
  logic [3:0]  MWSTB = '0;
  logic [31:0] MDATAI;
  logic        STALL;
  logic        ERR;
  logic        BUS_VALID;
  logic        BUS_READY;
  logic        BUS_WRITE;
  logic [29:0] BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [3:0]  BUS_WSTB;
  logic        BUS_RVALID;
  logic [31:0] BUS_RDATA;
  logic        BUS_ERR;

  always #5 CLK = ~CLK;

  dmem_bus_ctrl #(.TIMEOUT(T), .TW(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_RD    (REQ_RD),
    .REQ_WR    (REQ_WR),
    .MADDR     (MADDR),
    .MDATAO    (MDATAO),
    .MWSTB     (MWSTB),
    .MDATAI    (MDATAI),
    .STALL     (STALL),
    .ERR       (ERR),
    .BUS_VALID (BUS_VALID),
    .BUS_READY (BUS_READY),
    .BUS_WRITE (BUS_WRITE),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_WDATA (BUS_WDATA),
    .BUS_WSTB  (BUS_WSTB),
    .BUS_RVALID(BUS_RVALID),
    .BUS_RDATA (BUS_RDATA),
    .BUS_ERR   (BUS_ERR)
  );

  typedef struct {
    bit          wr;
    int          d;
    int          r;
    bit          e;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] mdat;
    bit          err;
    int          stall;
  } exp_t;

  typedef struct {
    logic [29:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  stb;
  } bus_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [31:0] mdat_m = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mdatai"}, MDATAI, 32'h0);
    chk({tag, "_err"}, 32'(ERR), 32'h0);
    chk({tag, "_valid"}, 32'(BUS_VALID), 32'h0);
    chk({tag, "_write"}, 32'(BUS_WRITE), 32'h0);
    chk({tag, "_addr"}, 32'(BUS_ADDR), 32'h0);
    chk({tag, "_wdata"}, BUS_WDATA, 32'h0);
    chk({tag, "_wstb"}, 32'(BUS_WSTB), 32'h0);
  endtask

  // Bus responder: follows the per-transaction plan, random noise
  // elsewhere (stray RVALID, meaningless BUS_ERR).
  initial begin
    plan_t pl;
    BUS_READY  = 1'b0;
    BUS_RVALID = 1'b0;
    BUS_RDATA  = '0;
    BUS_ERR    = 1'b0;
    forever begin
      @(negedge CLK);
      BUS_READY  = 1'b0;
      BUS_RVALID = ($urandom_range(3) == 0);
      BUS_RDATA  = $urandom;
      BUS_ERR    = 1'($urandom);
      if (BUS_VALID && plan_q.size() > 0) begin
        pl = plan_q.pop_front();
        for (int k = 0; k < T; k++) begin
          if (k > 0) begin
            @(negedge CLK);
            BUS_RVALID = ($urandom_range(3) == 0);
            BUS_RDATA  = $urandom;
            BUS_ERR    = 1'($urandom);
          end
          BUS_READY = (k == pl.d);
          if (k == pl.d) begin
            if (pl.wr) BUS_ERR = pl.e;
            break;
          end
        end
        if (!pl.wr && pl.d < T) begin
          for (int k = 0; k < T; k++) begin
            @(negedge CLK);
            BUS_READY  = 1'b0;
            BUS_RVALID = (k == pl.r);
            BUS_RDATA  = (k == pl.r) ? pl.rdata : $urandom;
            BUS_ERR    = (k == pl.r) ? pl.e : 1'($urandom);
            if (k == pl.r) break;
          end
        end
      end
    end
  end

  // Monitor: completion, bus-phase and ERR-pulse checks.
  initial begin
    exp_t ex;
    bus_t bx;
    int   sc = 0;
    bit   pv = 1'b0;
    bit   rq;
    forever begin
      @(negedge CLK);
      rq = REQ_RD | REQ_WR;
      if (!mon_en) begin
        sc = 0;
        pv = 1'b0;
      end else begin
        if (REQ_RD && REQ_WR) begin
          errors++;
          $display("FAIL illegal_req: REQ_RD and REQ_WR both high at %0t",
                   $time);
        end
        if (rq && STALL) begin
          sc++;
        end else if (rq) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL completion: got unexpected release, no entry");
          end else begin
            ex = exp_q.pop_front();
            chk("stall_cycles", 32'(sc), 32'(ex.stall));
            chk("mdatai", MDATAI, ex.mdat);
            chk("err_done", 32'(ERR), 32'(ex.err));
          end
          sc = 0;
        end
        if (!(rq && !STALL)) chk("err_outside_done", 32'(ERR), 32'h0);
        if (BUS_VALID) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_phase: got BUS_VALID with no access pending");
          end else begin
            bx = bus_q[0];
            chk("bus_addr", 32'(BUS_ADDR), 32'(bx.addr));
            chk("bus_write", 32'(BUS_WRITE), 32'(bx.wr));
            chk("bus_wstb", 32'(BUS_WSTB), 32'(bx.stb));
            if (bx.wr) chk("bus_wdata", BUS_WDATA, bx.wdata);
          end
        end else if (pv && bus_q.size() > 0) begin
          void'(bus_q.pop_front());
        end
        pv = BUS_VALID;
      end
    end
  end

  // One access from the M stage; the model derives the outcome from the
  // bus plan: d = ADDR cycles before READY, r = RWAIT cycles before RVALID.
  task automatic txn(input bit wr, input logic [29:0] a,
                     input logic [31:0] wd, input logic [3:0] stb,
                     input int d, input int r, input bit e,
                     input logic [31:0] rd);
    exp_t ex;
    bit   done;
    plan_q.push_back('{wr, d, r, e, rd});
    bus_q.push_back('{a, wr, wd, wr ? stb : 4'h0});
    if (wr) begin
      ex.err   = (d >= T) || e;
      ex.stall = 1 + ((d >= T) ? T : d + 1);
    end else if (d >= T) begin
      ex.err   = 1'b1;
      mdat_m   = '0;
      ex.stall = 1 + T;
    end else begin
      ex.err   = (r >= T) || e;
      mdat_m   = ex.err ? 32'h0 : rd;
      ex.stall = 2 + d + ((r >= T) ? T : r + 1);
    end
    ex.mdat = mdat_m;
    exp_q.push_back(ex);
    REQ_WR = wr;
    REQ_RD = !wr;
    MADDR  = a;
    MDATAO = wd;
    MWSTB  = stb;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (!STALL) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL access_hang: got STALL stuck high, required release");
      $fatal(1, "access did not complete");
    end
    @(posedge CLK);
    #1;
    REQ_WR = 1'b0;
    REQ_RD = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    @(negedge CLK);
    chk_reset_outputs("reset");
    chk("reset_stall", 32'(STALL), 32'h0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;

    txn(0, 30'h40, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEEF);
    gap(1);
    txn(1, 30'h123, 32'h00AB0000, 4'b0100, 3, 0, 0, 32'h0);
    gap(2);
    txn(0, 30'h200, 32'h0, 4'hF, 1, 0, 1, 32'h12345678);
    txn(0, 30'h204, 32'h0, 4'h0, 0, 2, 0, 32'hCAFEF00D);
    txn(1, 30'h208, 32'h55AA55AA, 4'hF, 9, 0, 0, 32'h0);
    txn(0, 30'h20C, 32'h0, 4'h0, 9, 0, 0, 32'h0);
    txn(0, 30'h210, 32'h0, 4'h0, 0, 0, 0, 32'h0BADF00D);
    txn(0, 30'h214, 32'h0, 4'h0, 1, 7, 0, 32'h0);
    gap(3);
    txn(0, 30'h300, 32'h0, 4'h0, 0, 0, 0, 32'h13572468);
    txn(1, 30'h304, 32'hA5A5A5A5, 4'b0011, 0, 0, 1, 32'h0);

    for (int n = 0; n < 150; n++) begin
      bit wr;
      int d;
      int r;
      wr = 1'($urandom);
      d  = ($urandom_range(7) == 0) ? 4 + $urandom_range(2)
                                    : $urandom_range(3);
      r  = ($urandom_range(7) == 0) ? 4 + $urandom_range(2)
                                    : $urandom_range(3);
      txn(wr, 30'($urandom), $urandom, 4'($urandom), d, r,
          ($urandom_range(5) == 0), $urandom);
      gap($urandom_range(2));
    end

    txn(0, 30'h3FF_0001, 32'h0, 4'h0, 0, 0, 0, 32'h89ABCDEF);
    gap(2);

    // Reset while the read waits in RWAIT.
    mon_en = 1'b0;
    plan_q.push_back('{1'b0, 0, 2, 1'b0, 32'h77777777});
    REQ_RD = 1'b1;
    MADDR  = 30'h2AAA_AAAA;
    MWSTB  = 4'hF;
    repeat (3) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    REQ_RD = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N  = 1'b1;
    mdat_m = '0;
    bus_q.delete();
    exp_q.delete();
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    txn(0, 30'h44, 32'h0, 4'h0, 0, 0, 0, 32'hFEEDFACE);
    gap(5);

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("plan_q_drained", 32'(plan_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
